// File: rtl/mult_div_unit_pkg.sv
// Shared encodings for the multiply/divide unit: MDControl opcodes (also used by
// the ALU decoder), FSM states and iteration sizing.
package mult_div_unit_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned ITERATIONS = 32;
  localparam int unsigned CNT_W      = $clog2(ITERATIONS);

  typedef enum logic [2:0] {
    MD_NONE  = 3'b000,
    MD_MULT  = 3'b001,
    MD_MULTU = 3'b010,
    MD_DIV   = 3'b011,
    MD_DIVU  = 3'b100,
    MD_MTHI  = 3'b101,
    MD_MTLO  = 3'b110,
    MD_RSVD  = 3'b111
  } md_ctrl_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DIV  = 2'b10,
    DONE = 2'b11
  } mdu_state_e;

  function automatic logic is_signed_op(input logic [2:0] ctrl);
    return (ctrl == MD_MULT) || (ctrl == MD_DIV);
  endfunction

endpackage

// File: rtl/mult_div_unit_sign_fix.sv
// Combinational sign handling: operand magnitudes on the way in, conditional
// negation of the 64-bit product or quotient/remainder on the way out.
module mdu_sign_fix
  import mult_div_unit_pkg::*;
(
  input  logic            i_signed,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic [XLEN-1:0] o_mag_a,
  output logic [XLEN-1:0] o_mag_b,
  output logic            o_neg_res,
  output logic            o_neg_rem,
  input  logic            i_is_div,
  input  logic            i_neg_res,
  input  logic            i_neg_rem,
  input  logic [XLEN-1:0] i_hi_mag,
  input  logic [XLEN-1:0] i_lo_mag,
  output logic [XLEN-1:0] o_hi,
  output logic [XLEN-1:0] o_lo
);

  logic [2*XLEN-1:0] w_prod_neg;

  assign w_prod_neg = -{i_hi_mag, i_lo_mag};

  always_comb begin
    o_mag_a   = (i_signed && i_a[XLEN-1]) ? -i_a : i_a;
    o_mag_b   = (i_signed && i_b[XLEN-1]) ? -i_b : i_b;
    o_neg_res = i_signed && (i_a[XLEN-1] ^ i_b[XLEN-1]);
    o_neg_rem = i_signed && i_a[XLEN-1];
    if (i_is_div) begin
      // Quotient follows the sign rule, remainder follows the dividend.
      o_lo = i_neg_res ? -i_lo_mag : i_lo_mag;
      o_hi = i_neg_rem ? -i_hi_mag : i_hi_mag;
    end else begin
      o_hi = i_neg_res ? w_prod_neg[2*XLEN-1:XLEN] : i_hi_mag;
      o_lo = i_neg_res ? w_prod_neg[XLEN-1:0]      : i_lo_mag;
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative 32-cycle multiply/divide unit with HI/LO result registers.
// Shift-add multiply and restoring divide share one {hi,lo} working pair.
module mult_div_unit
  import mult_div_unit_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  input  logic [2:0]      MDControl,
  input  logic            Start,
  output logic            Busy,
  output logic            Done,
  output logic            DivByZero,
  output logic [XLEN-1:0] HI,
  output logic [XLEN-1:0] LO
);

  mdu_state_e      r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [XLEN-1:0] r_work_hi, w_work_hi_nxt;
  logic [XLEN-1:0] r_work_lo, w_work_lo_nxt;
  logic [XLEN-1:0] r_mcand, w_mcand_nxt;
  logic [XLEN-1:0] r_src_a, w_src_a_nxt;
  logic [XLEN-1:0] r_hi, w_hi_nxt;
  logic [XLEN-1:0] r_lo, w_lo_nxt;
  logic            r_is_div, w_is_div_nxt;
  logic            r_neg_res, w_neg_res_nxt;
  logic            r_neg_rem, w_neg_rem_nxt;
  logic            r_div0, w_div0_nxt;
  logic            r_busy, w_busy_nxt;
  logic            r_done, w_done_nxt;
  logic            r_dbz, w_dbz_nxt;

  logic [XLEN-1:0] w_mag_a, w_mag_b, w_fix_hi, w_fix_lo;
  logic            w_neg_res, w_neg_rem, w_op_signed, w_last;
  logic [XLEN:0]   w_mul_sum, w_div_shift;
  logic [XLEN-1:0] w_div_diff;
  logic            w_div_ge;
  logic [XLEN-1:0] w_step_hi, w_step_lo;

  assign w_op_signed = is_signed_op(MDControl);
  assign w_last      = (r_cnt == CNT_W'(ITERATIONS - 1));

  // One shift-add multiply step: conditionally add, then shift {carry,hi,lo} right.
  assign w_mul_sum = {1'b0, r_work_hi} + (r_work_lo[0] ? {1'b0, r_mcand} : (XLEN+1)'(0));

  // One restoring divide step: shift dividend bit into remainder, subtract if it fits.
  assign w_div_shift = {r_work_hi, r_work_lo[XLEN-1]};
  assign w_div_ge    = (w_div_shift >= {1'b0, r_mcand});
  assign w_div_diff  = w_div_shift[XLEN-1:0] - r_mcand;

  always_comb begin
    if (r_is_div) begin
      w_step_hi = w_div_ge ? w_div_diff : w_div_shift[XLEN-1:0];
      w_step_lo = {r_work_lo[XLEN-2:0], w_div_ge};
    end else begin
      w_step_hi = w_mul_sum[XLEN:1];
      w_step_lo = {w_mul_sum[0], r_work_lo[XLEN-1:1]};
    end
  end

  mdu_sign_fix u_sign_fix (
    .i_signed  (w_op_signed),
    .i_a       (SrcA),
    .i_b       (SrcB),
    .o_mag_a   (w_mag_a),
    .o_mag_b   (w_mag_b),
    .o_neg_res (w_neg_res),
    .o_neg_rem (w_neg_rem),
    .i_is_div  (r_is_div),
    .i_neg_res (r_neg_res),
    .i_neg_rem (r_neg_rem),
    .i_hi_mag  (w_step_hi),
    .i_lo_mag  (w_step_lo),
    .o_hi      (w_fix_hi),
    .o_lo      (w_fix_lo)
  );

  // Next-state and datapath control.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_work_hi_nxt = r_work_hi;
    w_work_lo_nxt = r_work_lo;
    w_mcand_nxt   = r_mcand;
    w_src_a_nxt   = r_src_a;
    w_hi_nxt      = r_hi;
    w_lo_nxt      = r_lo;
    w_is_div_nxt  = r_is_div;
    w_neg_res_nxt = r_neg_res;
    w_neg_rem_nxt = r_neg_rem;
    w_div0_nxt    = r_div0;
    w_busy_nxt    = 1'b0;
    w_done_nxt    = 1'b0;
    w_dbz_nxt     = r_dbz;

    unique case (r_state)
      IDLE: begin
        if (Start) begin
          unique case (md_ctrl_e'(MDControl))
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
              w_is_div_nxt  = (MDControl == MD_DIV) || (MDControl == MD_DIVU);
              w_state_nxt   = w_is_div_nxt ? DIV : MUL;
              w_cnt_nxt     = '0;
              w_work_hi_nxt = '0;
              w_work_lo_nxt = w_mag_a;
              w_mcand_nxt   = w_mag_b;
              w_src_a_nxt   = SrcA;
              w_neg_res_nxt = w_neg_res;
              w_neg_rem_nxt = w_neg_rem;
              w_div0_nxt    = (SrcB == '0);
              w_busy_nxt    = 1'b1;
              w_dbz_nxt     = 1'b0;
            end
            MD_MTHI: w_hi_nxt = SrcA;
            MD_MTLO: w_lo_nxt = SrcA;
            default: ;
          endcase
        end
      end
      MUL, DIV: begin
        w_work_hi_nxt = w_step_hi;
        w_work_lo_nxt = w_step_lo;
        w_cnt_nxt     = r_cnt + CNT_W'(1);
        w_busy_nxt    = 1'b1;
        if (w_last) begin
          w_state_nxt = DONE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          if (r_is_div && r_div0) begin
            w_hi_nxt  = r_src_a;
            w_lo_nxt  = '1;
            w_dbz_nxt = 1'b1;
          end else begin
            w_hi_nxt = w_fix_hi;
            w_lo_nxt = w_fix_lo;
          end
        end
      end
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_work_hi <= '0;
      r_work_lo <= '0;
      r_mcand   <= '0;
      r_src_a   <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_is_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_div0    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_dbz     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_work_hi <= w_work_hi_nxt;
      r_work_lo <= w_work_lo_nxt;
      r_mcand   <= w_mcand_nxt;
      r_src_a   <= w_src_a_nxt;
      r_hi      <= w_hi_nxt;
      r_lo      <= w_lo_nxt;
      r_is_div  <= w_is_div_nxt;
      r_neg_res <= w_neg_res_nxt;
      r_neg_rem <= w_neg_rem_nxt;
      r_div0    <= w_div0_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_dbz     <= w_dbz_nxt;
    end
  end

  assign Busy      = r_busy;
  assign Done      = r_done;
  assign DivByZero = r_dbz;
  assign HI        = r_hi;
  assign LO        = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: vector table with a result scoreboard,
// randomized ops against an arithmetic model, and hand-written corner sequences.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  logic        clk;
  logic        reset_n;
  logic [31:0] SrcA, SrcB;
  logic [2:0]  MDControl;
  logic        Start;
  logic        Busy, Done, DivByZero;
  logic [31:0] HI, LO;

  mult_div_unit dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .MDControl (MDControl),
    .Start     (Start),
    .Busy      (Busy),
    .Done      (Done),
    .DivByZero (DivByZero),
    .HI        (HI),
    .LO        (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } vec_t;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [2:0] ctrl, input logic [31:0] a, input logic [31:0] b);
    SrcA = a; SrcB = b; MDControl = ctrl; Start = 1'b1;
    tick();
    Start = 1'b0; MDControl = MD_NONE;
  endtask

  task automatic wait_done(input string nm);
    int k = 0;
    while (!Done && k < 60) begin
      tick();
      k++;
    end
    if (!Done) chk({nm, "_timeout"}, 64'(Done), 64'd1);
  endtask

  task automatic pop_check(input string nm);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk({nm, "_sb_empty"}, 64'(sb_q.size()), 64'd1);
    end else begin
      e = sb_q.pop_front();
      chk({nm, "_hi"}, 64'(HI), 64'(e.hi));
      chk({nm, "_lo"}, 64'(LO), 64'(e.lo));
      chk({nm, "_dbz"}, 64'(DivByZero), 64'(e.dbz));
    end
  endtask

  // Full operation with timing checks: latency, Busy width, HI/LO hold, Done width.
  task automatic run_op(input string nm, input vec_t v);
    logic [31:0] hi0, lo0;
    int k, busy_cnt;
    bit held;
    hi0 = HI; lo0 = LO;
    sb_q.push_back('{hi: v.hi, lo: v.lo, dbz: v.dbz});
    start_op(v.ctrl, v.a, v.b);
    chk({nm, "_dbz_at_accept"}, 64'(DivByZero), 64'd0);
    k = 0; busy_cnt = 0; held = 1'b1;
    while (!Done && k < 40) begin
      if (Busy) busy_cnt++;
      if (HI !== hi0 || LO !== lo0) held = 1'b0;
      tick();
      k++;
    end
    chk({nm, "_latency"}, 64'(k), 64'd32);
    chk({nm, "_busy_cycles"}, 64'(busy_cnt), 64'd32);
    chk({nm, "_hold_while_busy"}, 64'(held), 64'd1);
    pop_check(nm);
    tick();
    chk({nm, "_done_width"}, 64'({Done, Busy}), 64'd0);
  endtask

  vec_t vecs[10];

  initial begin
    vec_t v;
    logic [31:0] ra, rb;
    logic [63:0] p;
    int sa, sb;

    vecs[0] = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[1] = '{MD_MULT,  32'hFFFFFFFB, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
    vecs[2] = '{MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3] = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[4] = '{MD_DIVU,  32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1'b1};
    vecs[5] = '{MD_MULTU, 32'h00000002, 32'h00000003, 32'h00000000, 32'h00000006, 1'b0};
    vecs[6] = '{MD_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[7] = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[8] = '{MD_DIV,   32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1};
    vecs[9] = '{MD_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0};

    reset_n = 1'b0; Start = 1'b0; MDControl = MD_NONE; SrcA = '0; SrcB = '0;
    // Start during reset must be ignored.
    SrcA = 32'hDEADBEEF; MDControl = MD_MTHI; Start = 1'b1;
    tick(); tick();
    chk("reset_hi", 64'(HI), 64'd0);
    chk("reset_lo", 64'(LO), 64'd0);
    chk("reset_flags", 64'({Busy, Done, DivByZero}), 64'd0);
    Start = 1'b0; MDControl = MD_NONE;
    reset_n = 1'b1;

    // MTHI / MTLO
    SrcA = 32'h12345678; MDControl = MD_MTHI; Start = 1'b1;
    tick();
    Start = 1'b0;
    chk("mthi_hi", 64'(HI), 64'h12345678);
    chk("mthi_lo", 64'(LO), 64'd0);
    chk("mthi_flags", 64'({Busy, Done}), 64'd0);
    SrcA = 32'h9ABCDEF0; MDControl = MD_MTLO; Start = 1'b1;
    tick();
    Start = 1'b0;
    chk("mtlo_lo", 64'(LO), 64'h9ABCDEF0);
    chk("mtlo_hi", 64'(HI), 64'h12345678);
    tick();
    chk("mtlo_flags", 64'({Busy, Done}), 64'd0);

    // Reserved and none opcodes are ignored.
    SrcA = 32'h0BADF00D; MDControl = MD_RSVD; Start = 1'b1;
    tick();
    MDControl = MD_NONE;
    tick();
    Start = 1'b0;
    chk("rsvd_ignored", {HI, LO}, {32'h12345678, 32'h9ABCDEF0});
    chk("rsvd_busy", 64'(Busy), 64'd0);

    for (int i = 0; i < 10; i++) run_op($sformatf("vec%0d", i), vecs[i]);

    // Random ops against an arithmetic model.
    for (int i = 0; i < 16; i++) begin
      ra = $urandom; rb = $urandom;
      if (rb == 0) rb = 32'd1;
      v.a = ra; v.b = rb; v.dbz = 1'b0;
      unique case (i % 4)
        0: begin v.ctrl = MD_MULTU; p = {32'd0, ra} * {32'd0, rb}; v.hi = p[63:32]; v.lo = p[31:0]; end
        1: begin v.ctrl = MD_MULT; p = 64'(longint'($signed(ra)) * longint'($signed(rb)));
                 v.hi = p[63:32]; v.lo = p[31:0]; end
        2: begin v.ctrl = MD_DIVU; v.hi = ra % rb; v.lo = ra / rb; end
        default: begin
          v.ctrl = MD_DIV;
          if (ra == 32'h80000000 && rb == 32'hFFFFFFFF) begin rb = 32'd3; v.b = rb; end
          sa = ra; sb = rb;
          v.hi = 32'(sa % sb); v.lo = 32'(sa / sb);
        end
      endcase
      run_op($sformatf("rnd%0d", i), v);
    end

    // Operand change and Start during an operation are ignored.
    sb_q.push_back('{hi: 32'd2, lo: 32'd14, dbz: 1'b0});
    start_op(MD_DIVU, 32'd100, 32'd7);
    repeat (5) tick();
    SrcA = 32'hFFFF0000; SrcB = 32'd3; MDControl = MD_MULT; Start = 1'b1;
    tick();
    Start = 1'b0; MDControl = MD_NONE;
    chk("midop_busy", 64'(Busy), 64'd1);
    wait_done("midop");
    pop_check("midop");
    tick();

    // Reset mid-operation aborts it with no Done.
    start_op(MD_DIVU, 32'd100, 32'd7);
    repeat (10) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("midrst_hilo", {HI, LO}, 64'd0);
    chk("midrst_flags", 64'({Busy, Done, DivByZero}), 64'd0);
    begin
      int done_seen = 0;
      for (int k = 0; k < 40; k++) begin
        if (Done || Busy) done_seen++;
        tick();
      end
      chk("midrst_no_done", 64'(done_seen), 64'd0);
    end

    // First Start after reset release is accepted at the next edge.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1; SrcA = 32'h00000055; MDControl = MD_MTLO; Start = 1'b1;
    tick();
    Start = 1'b0; MDControl = MD_NONE;
    chk("post_reset_accept", 64'(LO), 64'h55);

    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
